mul_pipe_rv: RTL and testbench

- Next-generation pipelined integer multiplier for the RV32M/RV64M execute stage.
- Computes the low or high XLEN bits of an XLEN x XLEN product for all four M-extension multiply ops (MUL, MULH, MULHSU, MULHU).
- Pipeline depth is configurable; throughput is one op per cycle with valid/ready flow control, backpressure, flush and a tag that travels with each op.
- Replaces the fixed XLEN-stage, unsigned-only, no-backpressure multiplier.

---
 rtl/mul_pipe_rv.sv | 149 ++++++++++++++
 tb/tb_mul_pipe_rv.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_rv.sv
`timescale 1ns/1ps
// Pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU), latency STAGES cycles, 1 op/cycle.
// Stalls whole pipe when valid_o & ~ready_i; MUL_PIPE_RV_CNT_EN adds a retired-op counter on cnt_o.
module mul_pipe_rv #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [31:0]      cnt_o
);

  localparam int CW = XLEN / STAGES;
  localparam int PW = 2 * XLEN;

  logic en;
  logic a_sgn, b_sgn;

  // Inputs seen by each stage's combinational slice.
  logic             s_vld [STAGES];
  logic [PW-1:0]    s_acc [STAGES];
  logic [XLEN:0]    s_a   [STAGES];
  logic [XLEN:0]    s_b   [STAGES];
  logic [1:0]       s_op  [STAGES];
  logic [TAG_W-1:0] s_tag [STAGES];

  // Low 2*XLEN bits of the extended product are exact under modular arithmetic.
  function automatic logic [PW-1:0] add_chunk(input logic [PW-1:0] acc,
                                               input logic [XLEN:0] a,
                                               input logic [XLEN:0] b,
                                               input int            k);
    logic [PW-1:0] ax;
    logic [PW-1:0] sum;
    logic [CW-1:0] bs;
    ax  = {{(XLEN-1){a[XLEN]}}, a};
    bs  = CW'(b >> (k * CW));
    sum = acc;
    for (int i = 0; i < CW; i++) begin
      if (bs[i]) sum = sum + (ax << (k * CW + i));
    end
    return sum;
  endfunction

  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  assign a_sgn = (op_i == 2'b01) | (op_i == 2'b10);
  assign b_sgn = (op_i == 2'b01);

  assign s_vld[0] = valid_i;
  assign s_acc[0] = '0;
  assign s_a[0]   = {a_sgn & a_i[XLEN-1], a_i};
  assign s_b[0]   = {b_sgn & b_i[XLEN-1], b_i};
  assign s_op[0]  = op_i;
  assign s_tag[0] = tag_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PW-1:0] acc_nxt;
    assign acc_nxt = add_chunk(s_acc[k], s_a[k], s_b[k], k);

    if (k < STAGES - 1) begin : g_mid
      logic             vld_q;
      logic [PW-1:0]    acc_q;
      logic [XLEN:0]    a_q;
      logic [XLEN:0]    b_q;
      logic [1:0]       op_q;
      logic [TAG_W-1:0] tag_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni)      vld_q <= 1'b0;
        else if (flush_i) vld_q <= 1'b0;
        else if (en)      vld_q <= s_vld[k];
      end

      // Payload of an empty stage is don't-care, so no reset is needed.
      always_ff @(posedge clk_i) begin
        if (en) begin
          acc_q <= acc_nxt;
          a_q   <= s_a[k];
          b_q   <= s_b[k];
          op_q  <= s_op[k];
          tag_q <= s_tag[k];
        end
      end

      assign s_vld[k+1] = vld_q;
      assign s_acc[k+1] = acc_q;
      assign s_a[k+1]   = a_q;
      assign s_b[k+1]   = b_q;
      assign s_op[k+1]  = op_q;
      assign s_tag[k+1] = tag_q;
    end else begin : g_last
      logic [PW-1:0]    ax_l;
      logic [PW-1:0]    prod;
      logic             vld_q;
      logic [XLEN-1:0]  res_q;
      logic [TAG_W-1:0] tag_q;

      // Sign bit of b carries weight -2^XLEN.
      assign ax_l = {{(XLEN-1){s_a[k][XLEN]}}, s_a[k]};
      assign prod = acc_nxt - (s_b[k][XLEN] ? (ax_l << XLEN) : '0);

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_q <= 1'b0;
          res_q <= '0;
          tag_q <= '0;
        end else begin
          if (flush_i)  vld_q <= 1'b0;
          else if (en)  vld_q <= s_vld[k];
          if (en && s_vld[k] && !flush_i) begin
            res_q <= (s_op[k] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
            tag_q <= s_tag[k];
          end
        end
      end

      assign valid_o  = vld_q;
      assign result_o = res_q;
      assign tag_o    = tag_q;
    end
  end

`ifdef MUL_PIPE_RV_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                cnt_q <= '0;
    else if (valid_o & ready_i) cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_pipe_rv.sv
`timescale 1ns/1ps
// Scoreboard bench for mul_pipe_rv: directed corners plus random traffic on 32x4 and 64-bit 1/2/32-stage builds.
module tb_mul_pipe_rv;

  localparam int XL = 32;
  localparam int ST = 4;
  localparam int TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [1:0]    op_i;
  logic [XL-1:0] a_i, b_i, result_o;
  logic [TW-1:0] tag_i, tag_o;
  logic [31:0]   cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit lat_exact = 1'b0;
  bit rnd_go = 1'b0;
  bit rnd_done = 1'b0;
  int wdone = 0;

  typedef struct {
    logic [63:0]   res;
    logic [TW-1:0] tag;
    int            t;
  } exp_t;

  always @(posedge clk) cyc <= cyc + 1;

  mul_pipe_rv #(.XLEN(XL), .STAGES(ST), .TAG_W(TW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o), .cnt_o(cnt_o)
  );

  // Reference: exact signed product of the extended operands, then pick a half.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int xl);
    logic [63:0] mask, a, b;
    logic signed [129:0] pa, pb, p, one;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    one = 130'sd1;
    pa = $signed({66'd0, a});
    pb = $signed({66'd0, b});
    if ((op == 2'b01 || op == 2'b10) && a[xl-1]) pa = pa - (one <<< xl);
    if (op == 2'b01 && b[xl-1]) pb = pb - (one <<< xl);
    p = pa * pb;
    if (op == 2'b00) return 64'(p) & mask;
    return 64'(p >>> xl) & mask;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- main-DUT scoreboard ----------------
  exp_t q[$];
  exp_t e_main;
  int hs = 0;
  logic pv = 1'b0, pr = 1'b1, pf = 1'b0;
  logic [XL-1:0] pres;
  logic [TW-1:0] ptag;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hs = 0;
      pv = 1'b0;
    end else begin
`ifdef MUL_PIPE_RV_CNT_EN
      chk("cnt", 64'(cnt_o), 64'(hs));
`else
      chk("cnt_tied", 64'(cnt_o), 64'd0);
`endif
      if (pv && !pr && !pf) begin
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_result", 64'(result_o), 64'(pres));
        chk("stall_tag", 64'(tag_o), 64'(ptag));
      end
      if (valid_o && !ready_i) chk("stall_ready", 64'(ready_o), 64'd0);
      if (valid_o && ready_i) begin
        hs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got result %h tag %h, expected no output", result_o, tag_o);
        end else begin
          e_main = q.pop_front();
          chk("result", 64'(result_o), e_main.res);
          chk("tag", 64'(tag_o), 64'(e_main.tag));
          if (lat_exact) chk("latency", 64'(cyc - e_main.t), 64'(ST));
        end
      end
      if (flush_i) q.delete();
      else if (valid_i && ready_o)
        q.push_back('{ref_mul(op_i, 64'(a_i), 64'(b_i), XL), tag_i, cyc});
      pv = valid_o; pr = ready_i; pf = flush_i; pres = result_o; ptag = tag_o;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b,
                       input logic [TW-1:0] tag);
    bit ok;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; tag_i = tag;
    ok = 1'b0;
    for (int w = 0; w < 500 && !ok; w++) begin
      @(negedge clk);
      if (ready_o) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got ready_o=0 for 500 cycles, expected 1");
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int w = 0; w < 500 && !idle; w++) begin
      @(negedge clk);
      if (q.size() == 0 && !valid_o) idle = 1'b1;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- 64-bit builds, random traffic only ----------------
  for (genvar g = 0; g < 3; g++) begin : g_wide
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 2 : 32;
    logic          w_vld, w_rdy, w_flush, w_vo, w_ri;
    logic [1:0]    w_op;
    logic [63:0]   w_a, w_b, w_res;
    logic [TW-1:0] w_tag, w_tago;
    logic [31:0]   w_cnt;
    exp_t          wq[$];
    exp_t          we;
    int            whs = 0;

    mul_pipe_rv #(.XLEN(64), .STAGES(WS), .TAG_W(TW)) u_wide (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(w_vld), .ready_o(w_rdy), .op_i(w_op),
      .a_i(w_a), .b_i(w_b), .tag_i(w_tag), .flush_i(w_flush), .valid_o(w_vo),
      .ready_i(w_ri), .result_o(w_res), .tag_o(w_tago), .cnt_o(w_cnt)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        wq.delete();
        whs = 0;
      end else begin
`ifdef MUL_PIPE_RV_CNT_EN
        chk("wide_cnt", 64'(w_cnt), 64'(whs));
`else
        chk("wide_cnt_tied", 64'(w_cnt), 64'd0);
`endif
        if (w_vo && w_ri) begin
          whs++;
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL wide_unexpected_out: got result %h, expected no output (stages %0d)", w_res, WS);
          end else begin
            we = wq.pop_front();
            chk("wide_result", w_res, we.res);
            chk("wide_tag", 64'(w_tago), 64'(we.tag));
            chk("wide_lat_min", 64'(cyc - we.t >= WS), 64'd1);
          end
        end
        if (w_vld && w_rdy) wq.push_back('{ref_mul(w_op, w_a, w_b, 64), w_tag, cyc});
      end
    end

    initial begin : drv
      int  sent, guard;
      bit  took;
      w_vld = 1'b0; w_flush = 1'b0; w_ri = 1'b1; w_op = 2'b00;
      w_a = '0; w_b = '0; w_tag = '0;
      wait (rnd_go);
      sent = 0; guard = 0;
      while ((sent < 200 || w_vld) && guard < 20000) begin
        @(negedge clk);
        took = w_vld && w_rdy;
        if (took) sent++;
        @(posedge clk); #1;
        guard++;
        w_ri = ($urandom_range(0, 3) != 0);
        if (!w_vld || took) begin
          w_vld = (sent < 200) && ($urandom_range(0, 4) != 0);
          w_op  = 2'($urandom);
          w_a   = rnd64();
          w_b   = rnd64();
          w_tag = TW'($urandom);
        end
      end
      w_vld = 1'b0;
      w_ri  = 1'b1;
      for (int w = 0; w < 300 && (wq.size() != 0 || w_vo); w++) @(negedge clk);
      chk("wide_drained", 64'(wq.size()), 64'd0);
      wdone++;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int hs0;
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op_i = 2'b00; a_i = '0; b_i = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_cnt", 64'(cnt_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // All four ops on all-ones operands, back to back, exact latency.
    lat_exact = 1'b1;
    for (int i = 0; i < 4; i++) issue(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, TW'(i + 1));
    wait_idle();
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5);
    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd6);
    issue(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd7);
    issue(2'b10, 32'h0000_0000, 32'h8000_0000, 5'd8);
    wait_idle();

    // Stream with a 3-cycle consumer stall while results are present.
    lat_exact = 1'b0;
    fork
      for (int i = 0; i < 8; i++) issue(2'b00, XL'(i), XL'(i + 1), TW'(i));
      begin
        for (int w = 0; w < 40 && !valid_o; w++) @(negedge clk);
        @(posedge clk); #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    wait_idle();

    // Flush with three ops in flight and a fourth presented on the flush cycle.
    lat_exact = 1'b1;
    hs0 = hs;
    issue(2'b00, 32'd3, 32'd5, 5'd11);
    issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12);
    issue(2'b01, 32'h8000_0001, 32'h7FFF_FFFF, 5'd13);
    valid_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9; tag_i = 5'd14; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", 64'(ready_o), 64'd1);
    issue(2'b00, 32'd7, 32'd9, 5'd15);
    wait_idle();
    chk("flush_handshakes", 64'(hs - hs0), 64'd1);
    lat_exact = 1'b0;

    // Reset with a full, stalled pipe.
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) issue(2'b00, XL'(i + 20), 32'd3, TW'(i + 20));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_valid", 64'(valid_o), 64'd0);
    chk("rst2_result", 64'(result_o), 64'd0);
    chk("rst2_tag", 64'(tag_o), 64'd0);
    chk("rst2_cnt", 64'(cnt_o), 64'd0);
    chk("rst2_ready", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Random traffic with random backpressure on every build.
    rnd_go = 1'b1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          issue(2'($urandom), XL'(rnd64() >> 32), XL'(rnd64() >> 32), TW'($urandom));
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        ready_i = ($urandom_range(0, 3) != 0);
      end
    join
    ready_i = 1'b1;
    wait_idle();
    for (int w = 0; w < 30000 && wdone < 3; w++) @(posedge clk);
    chk("wide_done", 64'(wdone), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
